// File: rtl/rc5_key_expand.sv
// RC5-16/r/16 key-schedule engine: expands a 128-bit user key into S[0..t-1], one init or mix step per cycle.
// s_rdata is an asynchronous read of the finished table, gated to zero until ready and beyond t.
module rc5_key_expand #(
  parameter int          W    = 16,
  parameter int          C    = 8,
  parameter int          TMAX = 32,
  parameter logic [15:0] P    = 16'hB7E1,
  parameter logic [15:0] Q    = 16'h9E37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   num_rounds,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         ready,
  input  logic [4:0]   s_raddr,
  output logic [15:0]  s_rdata
);

  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   s_q [TMAX];
  logic [W-1:0]   l_q [C];
  logic [5:0]     t_q, t_d;
  logic [4:0]     i_q, i_d;
  logic [2:0]     j_q, j_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [6:0]     step_q, step_d;
  logic           ready_q, ready_d;

  logic           s_we, l_we, l_load;
  logic [W-1:0]   s_wdat;
  logic [W-1:0]   init_val;
  logic [W-1:0]   a_new, b_new, ab_sum;
  logic [5:0]     i_next;
  logic [6:0]     n_cnt, n_last;

  // Rotate via a doubled word so a shift of 0 needs no special case.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [3:0] sh);
    logic [2*W-1:0] d;
    d = {x, x} << sh;
    return d[2*W-1:W];
  endfunction

  assign init_val = P + ({{(W-5){1'b0}}, i_q} * Q);
  assign a_new    = rotl(s_q[i_q] + a_q + b_q, 4'd3);
  assign ab_sum   = a_new + b_q;
  assign b_new    = rotl(l_q[j_q] + a_new + b_q, ab_sum[3:0]);
  assign i_next   = {1'b0, i_q} + 6'd1;

  // Mix length is 3*max(t,8); t never exceeds 32 so 7 bits suffice.
  assign n_cnt  = (t_q < 6'd8) ? 7'd24 : ({1'b0, t_q} + {t_q, 1'b0});
  assign n_last = n_cnt - 7'd1;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    step_d  = step_q;
    ready_d = ready_q;
    s_we    = 1'b0;
    s_wdat  = init_val;
    l_we    = 1'b0;
    l_load  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          l_load  = 1'b1;
          t_d     = {1'b0, num_rounds, 1'b0} + 6'd2;
          i_d     = 5'd0;
          a_d     = '0;
          b_d     = '0;
          ready_d = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        busy   = 1'b1;
        s_we   = 1'b1;
        s_wdat = init_val;
        if (i_next == t_q) begin
          i_d     = 5'd0;
          j_d     = 3'd0;
          step_d  = 7'd0;
          state_d = MIX;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      MIX: begin
        busy   = 1'b1;
        s_we   = 1'b1;
        s_wdat = a_new;
        l_we   = 1'b1;
        a_d    = a_new;
        b_d    = b_new;
        i_d    = (i_next == t_q) ? 5'd0 : i_q + 5'd1;
        j_d    = j_q + 3'd1;
        step_d = step_q + 7'd1;
        if (step_q == n_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      i_q     <= 5'd0;
      j_q     <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= 7'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      step_q  <= step_d;
      ready_q <= ready_d;
    end
  end

  // Table storage carries no reset; reads are masked by ready instead.
  always_ff @(posedge clk) begin
    if (s_we) begin
      s_q[i_q] <= s_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (l_load) begin
      for (int n = 0; n < C; n++) begin
        l_q[n] <= key[W*n +: W];
      end
    end else if (l_we) begin
      l_q[j_q] <= b_new;
    end
  end

  assign ready   = ready_q;
  assign s_rdata = (ready_q && ({1'b0, s_raddr} < t_q)) ? s_q[s_raddr] : 16'h0000;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Directed bench for rc5_key_expand: reset, latency per round count, table contents, ignored restarts,
// mid-run reset and back-to-back starts, checked against a behavioural RC5-16 key schedule.
module tb_rc5_key_expand;

  localparam logic [31:0] PW = 32'hB7E1;
  localparam logic [31:0] QW = 32'h9E37;

  logic         clk;
  logic         rst;
  logic         start;
  logic [3:0]   num_rounds;
  logic [127:0] key;
  logic         busy, done, ready;
  logic [4:0]   s_raddr;
  logic [15:0]  s_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] gold [32];

  rc5_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ready      (ready),
    .s_raddr    (s_raddr),
    .s_rdata    (s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rot(input logic [15:0] x, input int s);
    logic [15:0] hi, lo;
    if (s == 0) return x;
    hi = x << s;
    lo = x >> (16 - s);
    return hi | lo;
  endfunction

  // Reference schedule written from the byte-level key definition; unused slots expect 0.
  task automatic golden(input logic [127:0] k, input int r);
    logic [15:0] lw [8];
    logic [15:0] a, b;
    int t, n, ii, jj;
    t = 2 * (r + 1);
    n = 3 * ((t > 8) ? t : 8);
    for (int x = 0; x < 8; x++) lw[x] = {k[8*(2*x+1) +: 8], k[8*(2*x) +: 8]};
    for (int x = 0; x < 32; x++) gold[x] = (x < t) ? 16'(PW + x * QW) : 16'h0000;
    a = 16'h0; b = 16'h0; ii = 0; jj = 0;
    for (int s = 0; s < n; s++) begin
      a = rot(16'(gold[ii] + a + b), 3);
      gold[ii] = a;
      b = rot(16'(lw[jj] + a + b), int'(16'(a + b) % 16));
      lw[jj] = b;
      ii = (ii + 1) % t;
      jj = (jj + 1) % 8;
    end
  endtask

  // Starts a run, measures start-to-done latency; dist_at > 0 pulses start with a new key mid-run.
  task automatic run(input logic [127:0] k, input logic [3:0] r, input int lat,
                     input string tag, input int dist_at);
    int cycles, busy_gap, rdy_hi;
    key = k; num_rounds = r; start = 1'b1;
    golden(k, int'(r));
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_ready_drop"}, 32'(ready), 32'd0);
    cycles = 1; busy_gap = 0; rdy_hi = 0;
    while (!done && cycles < 400) begin
      if (dist_at > 0 && cycles == dist_at) begin
        start = 1'b1; key = ~k; num_rounds = r ^ 4'hF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (!done && !busy) busy_gap++;
      if (ready) rdy_hi++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'(lat));
    check({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
    check({tag, "_ready_during"}, 32'(rdy_hi), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_table(input string tag);
    for (int a = 0; a < 32; a++) begin
      s_raddr = 5'(a);
      #1;
      check($sformatf("%s_s%0d", tag, a), 32'(s_rdata), 32'(gold[a]));
    end
  endtask

  initial begin
    int extra;
    logic [127:0] rk, ka, kb;
    rst = 1'b0; start = 1'b1; key = '0; num_rounds = 4'd0; s_raddr = 5'd0;

    // reset held with start asserted
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_rdata", 32'(s_rdata), 32'd0);
    end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    run(128'h0, 4'd12, 105, "r12", 0);
    check_table("r12");

    run(128'h0F0E0D0C0B0A09080706050403020100, 4'd0, 27, "r0", 0);
    check_table("r0");

    rk = {$urandom, $urandom, $urandom, $urandom};
    run(rk, 4'd15, 129, "r15", 0);
    check_table("r15");

    // restart attempt mid-MIX with a different key and round count
    run(128'h00112233445566778899AABBCCDDEEFF, 4'd5, 49, "ign", 40);
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("ign_extra_done", 32'(extra), 32'd0);
    check_table("ign");

    // reset in the middle of MIX, then a fresh r=3 run
    ka = {$urandom, $urandom, $urandom, $urandom};
    key = ka; num_rounds = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_rdata", 32'(s_rdata), 32'd0);
    rst = 1'b1;
    kb = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    run(kb, 4'd3, 33, "mrst_r3", 0);
    check_table("mrst_r3");

    // second start in the idle cycle right after done
    run(128'h1, 4'd0, 27, "b2b1", 0);
    run(128'hFFFF0000FFFF0000A5A5A5A55A5A5A5A, 4'd3, 33, "b2b2", 0);
    check_table("b2b2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc5_key_expand.md
# rc5_key_expand

- RC5-16/r/16 key-schedule engine; sits directly upstream of the round datapath.
- Expands the 128-bit user key into the round-key table S[0..t-1] (16-bit words, t = 2·(num_rounds+1)) using the standard RC5 init-and-mix schedule, one mix step per cycle.
- Exposes S through an asynchronous read port that the encrypt/decrypt rounds index during each round.

## Interface
Parameters:
- W, 16, word width (fixed; rotation amounts use log2(W)=4 bits)
- C, 8, key words (128/W)
- TMAX, 32, S-table depth (t for num_rounds=15)
- P, 16'hB7E1, magic constant P16
- Q, 16'h9E37, magic constant Q16

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request expansion; sampled only in IDLE
- num_rounds  in  4  round count r (not 0-indexed, 0..15); latched on accepted start
- key  in  128  user key; K[n] = key[8n+7:8n]; latched on accepted start
- busy  out  1  high in INIT and MIX
- done  out  1  one-cycle pulse in DONE state
- ready  out  1  S table valid for current latched key/rounds
- s_raddr  in  5  S read index
- s_rdata  out  16  S[s_raddr] when ready && s_raddr < t, else 16'h0000 (combinational)

## Operation
- Storage: S[0..31] and L[0..7] register arrays (16-bit), t_reg (6 bits), i (5 bits), j (3 bits), A, B (16 bits), step counter (7 bits).
- States: IDLE, INIT, MIX, DONE.
- IDLE, start=1:
  - L[n] = key[16n+15:16n] (little-endian byte pack).
  - t_reg = 2·(num_rounds+1).
  - i=0, A=B=0; ready=0.
  - Go to INIT.
- IDLE, start=0: hold.
- INIT: one word per cycle, S[i] = P + i·Q mod 2^16; i++.
  - After writing S[t_reg-1]: i=0, j=0, step=0; go to MIX.
- MIX: n = 3·max(t_reg, 8) iterations, one per cycle. Each cycle:
  - A' = (S[i]+A+B) <<< 3; S[i] = A'.
  - B' = (L[j]+A'+B) <<< ((A'+B) mod 16); L[j] = B'.
  - A=A', B=B'.
  - i = (i+1 == t_reg) ? 0 : i+1; j = (j+1) mod 8 (natural 3-bit wrap).
  - All additions are mod 2^16 (carries discarded). Rotation by 0 is identity.
  - After step n-1: go to DONE.
- DONE: done=1, ready set (registered, visible next cycle and after). Go to IDLE.
- ready stays high in IDLE until the next accepted start or reset.
- start in INIT/MIX/DONE is ignored (no queuing). key/num_rounds changes outside IDLE have no effect.
- Reset (any state, including mid-MIX): state=IDLE, busy=0, done=0, ready=0, A=B=0, counters=0. S/L contents are don't-care; s_rdata reads 0 because ready=0.

## Timing
- start sampled high at edge k:
  - INIT occupies cycles k+1..k+t.
  - MIX occupies cycles k+t+1..k+t+n.
  - done is high in cycle k+t+n+1; ready is high from cycle k+t+n+2.
- Latency (edge k to done cycle):
  - r=0: t=2, n=24, 27 cycles.
  - r=3: t=8, n=24, 33 cycles.
  - r=12: t=26, n=78, 105 cycles.
  - r=15: t=32, n=96, 129 cycles.
- ready falls in cycle k+1 after an accepted start.
- busy is high exactly for cycles k+1..k+t+n.
- A new start is accepted in the cycle after done (IDLE), giving back-to-back operation.
- s_rdata is combinational from registered S/ready; no read latency.
- Reset is synchronous: rst=0 at an edge forces IDLE outputs in the following cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1 -> busy=0, done=0, ready=0, s_rdata=0 throughout.
- key=128'h0, r=12, start 1 cycle -> done pulse exactly 105 cycles later, 1 cycle wide. S[0..25] match the C golden model (RC5-16 key schedule). s_raddr 26..31 read 0.
- key=128'h0F0E0D0C0B0A09080706050403020100, r=0 -> done at 27 cycles. S[0..1] match golden. Addresses 2..31 read 0.
- r=15, random key -> done at 129 cycles, all 32 words match golden.
- Pulse start again at cycle 40 and change key/num_rounds mid-run -> ignored. Single done; table matches the originally latched key.
- Assert rst=0 mid-MIX, then restart with new key r=3 -> ready=0 immediately. Fresh run completes in 33 cycles; S matches golden for the new key.
- Back-to-back: second start in the cycle after done -> second done after the correct latency; ready low during the second run.
